lc3_mem_arbiter: RTL and testbench

Sequences the single LC-3 memory port and shares it between two requesters: port C (control unit fetch/load/store via MAR/MDR) and port L (preload/debug loader that writes program images before and during execution). It serialises transactions, applies the memory's fixed read latency, and returns read data with a one-cycle done pulse. It sits between LC3Control/MAR/MDR and the memory array.

---
 rtl/lc3_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter.sv
// LC-3 memory port arbiter: serialises control-unit (C) and loader (L) accesses
// onto a single fixed-latency memory port and returns read data with a done pulse.
module lc3_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              boot_mode,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // state | meaning
  // IDLE  | arbitrate, latch the winner's request fields
  // ISSUE | single mem_en strobe with latched request
  // WAIT  | count down read latency, capture mem_rdata at zero
  // DONE  | done pulse to owner, round-robin pointer moves to the other port

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t              state, state_nxt;
  logic                owner_l;
  logic                rr_l;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          cnt;
  logic                pick_any;
  logic                pick_l;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      owner_l <= 1'b0;
      rr_l    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= 3'd0;
      c_rdata <= '0;
      l_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner_l <= pick_l;
            we_q    <= pick_l ? l_we    : c_we;
            addr_q  <= pick_l ? l_addr  : c_addr;
            wdata_q <= pick_l ? l_wdata : c_wdata;
          end
        end
        ISSUE: begin
          if (!we_q) cnt <= LAT_LOAD;
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (owner_l) l_rdata <= mem_rdata;
            else         c_rdata <= mem_rdata;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: rr_l <= ~owner_l;
        default: ;
      endcase
    end
  end

  always_comb begin
    // boot_mode locks C out entirely; otherwise ties go to the rr pointer
    pick_any  = boot_mode ? l_req : (c_req | l_req);
    pick_l    = boot_mode ? l_req : (l_req & (~c_req | rr_l));
    state_nxt = state;
    c_gnt     = 1'b0;
    l_gnt     = 1'b0;
    c_done    = 1'b0;
    l_done    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (pick_any) state_nxt = ISSUE;
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        state_nxt = we_q ? DONE : WAIT;
      end
      WAIT:  if (cnt == 3'd0) state_nxt = DONE;
      DONE: begin
        c_done    = ~owner_l;
        l_done    = owner_l;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE) begin
      c_gnt = ~owner_l;
      l_gnt = owner_l;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: dut0 runs MEM_LAT=2, dut1 runs MEM_LAT=1,
// each with its own small memory model; a negedge monitor checks against queued expectations.
`timescale 1ns/1ps
module tb_lc3_mem_arbiter;

  typedef struct { int d; int cyc; logic we; logic [15:0] addr; logic [15:0] wdata; } mem_exp_t;
  typedef struct { int d; int cyc; logic is_l; logic [15:0] c_rd; logic [15:0] l_rd; } done_exp_t;
  typedef struct { int d; int cyc; logic zero; logic [15:0] c_rd; logic [15:0] l_rd; } chk_t;

  mem_exp_t  mem_q[$];
  done_exp_t done_q[$];
  chk_t      chk_q[$];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  reset_n, boot_mode, c_req, c_we, l_req, l_we;
  logic [15:0] c_addr [2], c_wdata [2], l_addr [2], l_wdata [2];
  logic [1:0]  c_gnt, c_done, l_gnt, l_done, mem_en, mem_we, busy;
  logic [15:0] c_rdata [2], l_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [15:0] mdl_c [2], mdl_l [2];

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) dut0 (
    .clk(clk), .reset_n(reset_n[0]), .boot_mode(boot_mode[0]),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_gnt(c_gnt[0]), .c_done(c_done[0]), .c_rdata(c_rdata[0]),
    .l_req(l_req[0]), .l_we(l_we[0]), .l_addr(l_addr[0]), .l_wdata(l_wdata[0]),
    .l_gnt(l_gnt[0]), .l_done(l_done[0]), .l_rdata(l_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

  lc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n[1]), .boot_mode(boot_mode[1]),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_gnt(c_gnt[1]), .c_done(c_done[1]), .c_rdata(c_rdata[1]),
    .l_req(l_req[1]), .l_we(l_we[1]), .l_addr(l_addr[1]), .l_wdata(l_wdata[1]),
    .l_gnt(l_gnt[1]), .l_done(l_done[1]), .l_rdata(l_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

  // Memory model: read data appears MEM_LAT edges after mem_en is sampled, junk otherwise
  logic [15:0] mem [2][256];
  logic [15:0] p0 [2];
  logic [15:0] p1 [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] && mem_we[d]) mem[d][mem_addr[d][7:0]] <= mem_wdata[d];
      p0[d] <= (mem_en[d] && !mem_we[d]) ? mem[d][mem_addr[d][7:0]] : 16'hBAD0;
      p1[d] <= p0[d];
    end
  end
  assign mem_rdata[0] = p1[0];
  assign mem_rdata[1] = p0[1];

  always @(negedge clk) begin
    mem_exp_t  me;
    done_exp_t de;
    chk_t      ck;
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d]) begin
        tests++;
        if (mem_q.size() == 0) begin
          fails++;
          $display("FAIL mem_access dut%0d cyc %0d: got unexpected mem_en, required none", d, cyc);
        end else begin
          me = mem_q.pop_front();
          if (me.d != d || me.cyc != cyc || me.we != mem_we[d] || me.addr != mem_addr[d] || me.wdata != mem_wdata[d]) begin
            fails++;
            $display("FAIL mem_access: got dut%0d cyc %0d we %0b addr %h wdata %h, required dut%0d cyc %0d we %0b addr %h wdata %h",
                     d, cyc, mem_we[d], mem_addr[d], mem_wdata[d], me.d, me.cyc, me.we, me.addr, me.wdata);
          end
        end
      end else if (mem_we[d]) begin
        tests++;
        fails++;
        $display("FAIL mem_we_alone dut%0d cyc %0d: got mem_we=1 without mem_en, required 0", d, cyc);
      end
      if (c_done[d] || l_done[d]) begin
        tests++;
        if (done_q.size() == 0) begin
          fails++;
          $display("FAIL done dut%0d cyc %0d: got c_done %0b l_done %0b, required none", d, cyc, c_done[d], l_done[d]);
        end else begin
          de = done_q.pop_front();
          if (de.d != d || de.cyc != cyc || c_done[d] != !de.is_l || l_done[d] != de.is_l ||
              c_rdata[d] != de.c_rd || l_rdata[d] != de.l_rd) begin
            fails++;
            $display("FAIL done: got dut%0d cyc %0d c/l_done %0b%0b c_rdata %h l_rdata %h, required dut%0d cyc %0d c/l_done %0b%0b c_rdata %h l_rdata %h",
                     d, cyc, c_done[d], l_done[d], c_rdata[d], l_rdata[d],
                     de.d, de.cyc, !de.is_l, de.is_l, de.c_rd, de.l_rd);
          end
        end
      end
      if (busy[d]) begin
        tests++;
        if (c_gnt[d] == l_gnt[d]) begin
          fails++;
          $display("FAIL gnt_onehot dut%0d cyc %0d: got c_gnt %0b l_gnt %0b, required exactly one", d, cyc, c_gnt[d], l_gnt[d]);
        end
      end
    end
    while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
      ck = chk_q.pop_front();
      tests++;
      if (ck.zero) begin
        if ({c_gnt[ck.d], l_gnt[ck.d], c_done[ck.d], l_done[ck.d], mem_en[ck.d], mem_we[ck.d], busy[ck.d]} != 7'd0 ||
            mem_addr[ck.d] != 16'h0 || mem_wdata[ck.d] != 16'h0 || c_rdata[ck.d] != 16'h0 || l_rdata[ck.d] != 16'h0) begin
          fails++;
          $display("FAIL reset_state dut%0d cyc %0d: got gnt %0b%0b done %0b%0b en %0b we %0b busy %0b addr %h wdata %h crd %h lrd %h, required all 0",
                   ck.d, cyc, c_gnt[ck.d], l_gnt[ck.d], c_done[ck.d], l_done[ck.d], mem_en[ck.d], mem_we[ck.d],
                   busy[ck.d], mem_addr[ck.d], mem_wdata[ck.d], c_rdata[ck.d], l_rdata[ck.d]);
        end
      end else if (c_rdata[ck.d] != ck.c_rd || l_rdata[ck.d] != ck.l_rd) begin
        fails++;
        $display("FAIL rdata_hold dut%0d cyc %0d: got c_rdata %h l_rdata %h, required %h %h",
                 ck.d, cyc, c_rdata[ck.d], l_rdata[ck.d], ck.c_rd, ck.l_rd);
      end
    end
    if (end_req && !end_ack) begin
      tests++;
      if (mem_q.size() != 0 || done_q.size() != 0 || chk_q.size() != 0) begin
        fails++;
        $display("FAIL drain: got %0d mem / %0d done / %0d state expectations left, required 0 0 0",
                 mem_q.size(), done_q.size(), chk_q.size());
      end
      end_ack = 1'b1;
    end
  end

  task automatic next_cycle(output int n);
    @(posedge clk);
    #1;
    n = cyc;
  endtask

  task automatic exp_txn(input int d, input int n, input bit is_l, input bit we,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] rd, input int lat);
    mem_q.push_back('{d, n + 1, we, addr, wdata});
    if (!we) begin
      if (is_l) mdl_l[d] = rd;
      else      mdl_c[d] = rd;
    end
    done_q.push_back('{d, we ? n + 2 : n + 2 + lat, is_l, mdl_c[d], mdl_l[d]});
  endtask

  task automatic push_chk(input int d, input int c, input bit zero,
                          input logic [15:0] crd, input logic [15:0] lrd);
    chk_q.push_back('{d, c, zero, crd, lrd});
  endtask

  task automatic set_c(input int d, input bit req, input bit we, input logic [15:0] a, input logic [15:0] w);
    c_req[d] = req; c_we[d] = we; c_addr[d] = a; c_wdata[d] = w;
  endtask

  task automatic set_l(input int d, input bit req, input bit we, input logic [15:0] a, input logic [15:0] w);
    l_req[d] = req; l_we[d] = we; l_addr[d] = a; l_wdata[d] = w;
  endtask

  task automatic wait_done(input int d, input bit is_l);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (is_l ? l_done[d] : c_done[d]) return;
    end
    $display("FAIL wait_done dut%0d port %s: got no done within 60 cycles, required one", d, is_l ? "L" : "C");
  endtask

  initial begin
    int n, k;
    reset_n = 2'b00; boot_mode = 2'b00;
    for (int d = 0; d < 2; d++) begin
      set_c(d, 0, 0, 16'h0, 16'h0);
      set_l(d, 0, 0, 16'h0, 16'h0);
      mdl_c[d] = 16'h0;
      mdl_l[d] = 16'h0;
    end
    repeat (3) next_cycle(n);
    push_chk(0, n, 1, 16'h0, 16'h0);
    push_chk(1, n, 1, 16'h0, 16'h0);
    next_cycle(n);
    reset_n = 2'b11;

    // C write then C read, MEM_LAT=2
    next_cycle(n);
    set_c(0, 1, 1, 16'h3001, 16'hE207);
    exp_txn(0, n, 0, 1, 16'h3001, 16'hE207, 16'h0, 2);
    push_chk(0, n + 3, 0, 16'h0, 16'h0);
    wait_done(0, 0);
    c_req[0] = 1'b0;
    next_cycle(n);
    set_c(0, 1, 0, 16'h3001, 16'hFFFF);
    exp_txn(0, n, 0, 0, 16'h3001, 16'hFFFF, 16'hE207, 2);
    push_chk(0, n + 7, 0, 16'hE207, 16'h0);
    wait_done(0, 0);
    c_req[0] = 1'b0;
    repeat (4) next_cycle(n);

    // both held from reset: C,L,C,L
    reset_n[0] = 1'b0;
    mdl_c[0] = 16'h0; mdl_l[0] = 16'h0;
    push_chk(0, n, 1, 16'h0, 16'h0);
    set_c(0, 1, 1, 16'h3010, 16'h1111);
    set_l(0, 1, 1, 16'h3020, 16'h2222);
    next_cycle(k);
    reset_n[0] = 1'b1;
    exp_txn(0, k,     0, 1, 16'h3010, 16'h1111, 16'h0, 2);
    exp_txn(0, k + 3, 1, 1, 16'h3020, 16'h2222, 16'h0, 2);
    exp_txn(0, k + 6, 0, 1, 16'h3010, 16'h1111, 16'h0, 2);
    exp_txn(0, k + 9, 1, 1, 16'h3020, 16'h2222, 16'h0, 2);
    wait_done(0, 0); wait_done(0, 1); wait_done(0, 0); wait_done(0, 1);
    c_req[0] = 1'b0; l_req[0] = 1'b0;

    // boot_mode: L every 3 cycles, then C once boot_mode drops
    next_cycle(n);
    boot_mode[0] = 1'b1;
    set_c(0, 1, 1, 16'h3030, 16'h3333);
    set_l(0, 1, 1, 16'h3040, 16'h4444);
    exp_txn(0, n,      1, 1, 16'h3040, 16'h4444, 16'h0, 2);
    exp_txn(0, n + 3,  1, 1, 16'h3040, 16'h4444, 16'h0, 2);
    exp_txn(0, n + 6,  1, 1, 16'h3040, 16'h4444, 16'h0, 2);
    exp_txn(0, n + 9,  0, 1, 16'h3030, 16'h3333, 16'h0, 2);
    exp_txn(0, n + 12, 1, 1, 16'h3040, 16'h4444, 16'h0, 2);
    wait_done(0, 1); wait_done(0, 1); wait_done(0, 1);
    boot_mode[0] = 1'b0;
    wait_done(0, 0); wait_done(0, 1);
    c_req[0] = 1'b0; l_req[0] = 1'b0;

    // C write leaves rr on L; L read then aborted by reset during WAIT
    next_cycle(n);
    set_c(0, 1, 1, 16'h3050, 16'h5555);
    exp_txn(0, n, 0, 1, 16'h3050, 16'h5555, 16'h0, 2);
    wait_done(0, 0);
    c_req[0] = 1'b0;
    next_cycle(n);
    set_c(0, 1, 1, 16'h3060, 16'h6666);
    set_l(0, 1, 0, 16'h3001, 16'h0000);
    mem_q.push_back('{0, n + 1, 1'b0, 16'h3001, 16'h0000});
    next_cycle(n);
    next_cycle(n);
    reset_n[0] = 1'b0;
    mdl_c[0] = 16'h0; mdl_l[0] = 16'h0;
    push_chk(0, n, 1, 16'h0, 16'h0);
    next_cycle(n);
    push_chk(0, n, 1, 16'h0, 16'h0);
    next_cycle(k);
    reset_n[0] = 1'b1;
    exp_txn(0, k,     0, 1, 16'h3060, 16'h6666, 16'h0, 2);
    exp_txn(0, k + 3, 1, 0, 16'h3001, 16'h0000, 16'hE207, 2);
    wait_done(0, 0);
    c_req[0] = 1'b0;
    wait_done(0, 1);
    l_req[0] = 1'b0;

    // MEM_LAT=1: L write, then L read with req dropped during WAIT
    next_cycle(n);
    set_l(1, 1, 1, 16'h3002, 16'h3200);
    exp_txn(1, n, 1, 1, 16'h3002, 16'h3200, 16'h0, 1);
    wait_done(1, 1);
    l_req[1] = 1'b0;
    next_cycle(n);
    set_l(1, 1, 0, 16'h3002, 16'h0000);
    exp_txn(1, n, 1, 0, 16'h3002, 16'h0000, 16'h3200, 1);
    next_cycle(n);
    next_cycle(n);
    l_req[1] = 1'b0;
    wait_done(1, 1);
    next_cycle(n);
    push_chk(1, n + 3, 0, 16'h0, 16'h3200);
    repeat (6) next_cycle(n);

    end_req = 1'b1;
    for (int i = 0; i < 5 && !end_ack; i++) @(posedge clk);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
